// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, the common baud constant
// and the bit-order aware shift helper.
package uart_pkg;

  // Clocks per bit at 27 MHz / 115200 baud, shared with the emitter.
  localparam int DELAY_FRAMES_DEFAULT = 234;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    RECV_BYTE = 3'd2,
    STOP_BIT  = 3'd3,
    WAIT_HIGH = 3'd4
  } state_e;

  // Insert one received bit into the shift register in line order.
  function automatic logic [7:0] shift_in(input logic [7:0] sh,
                                          input logic       b,
                                          input logic       msb_first);
    if (msb_first) begin
      return {sh[6:0], b};
    end
    return {b, sh[7:1]};
  endfunction

endpackage

// File: rtl/uart_receiver_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; reset to the line's idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 8 data bits, no parity, 1 stop bit. Samples bit centres,
// holds the byte until read, flags framing errors and overruns.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DELAY_FRAMES = DELAY_FRAMES_DEFAULT,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] dataOut,
  output logic       dataValid,
  input  logic       read,
  output logic       frameErr,
  output logic       overrun
);

  localparam int            CW   = $clog2(DELAY_FRAMES) + 1;
  localparam logic [CW-1:0] HALF = CW'(DELAY_FRAMES / 2);
  localparam logic [CW-1:0] LAST = CW'(DELAY_FRAMES);

  logic          rxs;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;

  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rxs)
  );

  assign cnt_inc = cnt_q + CW'(1);

  // State, counters and registered outputs; shift register needs no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
    shift_q <= shift_d;
  end

  // Next-state logic: frame sequencing plus the consumer handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (read && valid_q) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START_BIT;
          cnt_d   = '0;
        end
      end
      START_BIT: begin
        if (cnt_inc == HALF) begin
          cnt_d = '0;
          if (!rxs) begin
            state_d = RECV_BYTE;
            bit_d   = '0;
          end else begin
            // Start bit did not survive to mid-bit: treat as a glitch.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RECV_BYTE: begin
        if (cnt_inc == LAST) begin
          cnt_d   = '0;
          shift_d = shift_in(shift_q, rxs, MSB_FIRST);
          if (bit_q == 3'd7) begin
            state_d = STOP_BIT;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      STOP_BIT: begin
        if (cnt_inc == LAST) begin
          cnt_d = '0;
          if (rxs) begin
            // A same-cycle read makes room for the new byte, so no overrun.
            data_d  = shift_q;
            valid_d = 1'b1;
            ovr_d   = valid_q && !read;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_HIGH: begin
        // Hold off until the line returns high so a break flags only once.
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign dataOut   = data_q;
  assign dataValid = valid_q;
  assign frameErr  = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: table-driven frames on a shared
// line into an MSB-first and an LSB-first instance, plus corner sequences.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int DF = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       read;
  logic       read2;
  logic [7:0] dout_m, dout_l;
  logic       dv_m, dv_l, fe_m, fe_l, ov_m, ov_l;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0, ovr_cnt = 0, ferr_l_cnt = 0, ovr_l_cnt = 0;
  logic [7:0] exp_q[$];
  logic       prev_v = 1'b0;
  logic [7:0] prev_d = 8'h00;

  always #5 clk = ~clk;

  uart_receiver #(.DELAY_FRAMES(DF), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .rx(rx), .dataOut(dout_m), .dataValid(dv_m),
    .read(read), .frameErr(fe_m), .overrun(ov_m)
  );

  uart_receiver #(.DELAY_FRAMES(DF), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .rx(rx), .dataOut(dout_l), .dataValid(dv_l),
    .read(read2), .frameErr(fe_l), .overrun(ov_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: each newly presented byte must match the queue head.
  always @(negedge clk) begin
    if (fe_m) ferr_cnt++;
    if (ov_m) ovr_cnt++;
    if (fe_l) ferr_l_cnt++;
    if (ov_l) ovr_l_cnt++;
    if (dv_m && (!prev_v || dout_m != prev_d)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got %02h, required no byte", dout_m);
      end else begin
        chk("scoreboard_byte", {24'h0, dout_m}, {24'h0, exp_q.pop_front()});
      end
    end
    prev_v = dv_m;
    prev_d = dout_m;
  end

  task automatic send_frame(input logic [7:0] b, input bit lsb_first, input bit stop);
    rx = 1'b0;
    repeat (DF) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = lsb_first ? b[i] : b[7-i];
      repeat (DF) @(posedge clk);
      #1;
    end
    rx = stop;
    repeat (DF) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!dv_m && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic read_both();
    read  = 1'b1;
    read2 = 1'b1;
    @(posedge clk);
    #1;
    read  = 1'b0;
    read2 = 1'b0;
  endtask

  typedef struct {
    logic [7:0] tx;
    bit         lsb;
    logic [7:0] exp_m;
    logic [7:0] exp_l;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int n, f0, o0;
    tbl[0] = '{8'hA5, 1'b0, 8'hA5, 8'hA5};
    tbl[1] = '{8'h3C, 1'b1, 8'h3C, 8'h3C};
    tbl[2] = '{8'hC1, 1'b1, 8'h83, 8'hC1};
    tbl[3] = '{8'h12, 1'b0, 8'h12, 8'h48};
    tbl[4] = '{8'h00, 1'b0, 8'h00, 8'h00};
    tbl[5] = '{8'hFF, 1'b0, 8'hFF, 8'hFF};
    tbl[6] = '{8'h01, 1'b1, 8'h80, 8'h01};

    rst = 1'b1; rx = 1'b1; read = 1'b0; read2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dataOut", {24'h0, dout_m}, 32'h0);
    chk("reset_dataValid", {31'h0, dv_m}, 32'h0);
    chk("reset_frameErr", {31'h0, fe_m}, 32'h0);
    chk("reset_overrun", {31'h0, ov_m}, 32'h0);
    chk("reset_state", 32'(dut_m.state_q), 32'(IDLE));
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Table: each frame checked for latency, both bit orders and read-clear.
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(tbl[i].exp_m);
      fork
        send_frame(tbl[i].tx, tbl[i].lsb, 1'b1);
        wait_valid(200, n);
      join
      chk("latency_152_156", {31'h0, (n >= 152 && n <= 156)}, 32'h1);
      chk("msb_dataOut", {24'h0, dout_m}, {24'h0, tbl[i].exp_m});
      chk("lsb_dataOut", {24'h0, dout_l}, {24'h0, tbl[i].exp_l});
      chk("lsb_dataValid", {31'h0, dv_l}, 32'h1);
      read_both();
      chk("read_clears_valid", {31'h0, dv_m}, 32'h0);
      chk("read_clears_lsb_valid", {31'h0, dv_l}, 32'h0);
      repeat (8) @(posedge clk);
      #1;
    end
    chk("lsb_no_frameErr", 32'(ferr_l_cnt), 32'h0);
    chk("lsb_no_overrun", 32'(ovr_l_cnt), 32'h0);
    chk("table_no_overrun", 32'(ovr_cnt), 32'h0);

    // Three-clock low glitch on an idle line.
    f0 = ferr_cnt;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    chk("glitch_back_to_idle", 32'(dut_m.state_q), 32'(IDLE));
    repeat (40) @(posedge clk);
    #1;
    chk("glitch_no_valid", {31'h0, dv_m}, 32'h0);
    chk("glitch_no_frameErr", 32'(ferr_cnt - f0), 32'h0);

    // Bad stop bit followed by a long break, then a good frame.
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    repeat (40 * DF) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (2 * DF) @(posedge clk);
    #1;
    chk("break_one_frameErr", 32'(ferr_cnt - f0), 32'h1);
    chk("break_no_valid", {31'h0, dv_m}, 32'h0);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b0, 1'b1);
    wait_valid(50, n);
    chk("break_recover_timeout", {31'h0, (n < 50)}, 32'h1);
    chk("break_recover_data", {24'h0, dout_m}, 32'h12);
    chk("break_still_one_frameErr", 32'(ferr_cnt - f0), 32'h1);
    read_both();
    repeat (8) @(posedge clk);
    #1;

    // Back-to-back frames without a read: one overrun, newest byte kept.
    o0 = ovr_cnt;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("overrun_once", 32'(ovr_cnt - o0), 32'h1);
    chk("overrun_data", {24'h0, dout_m}, 32'h22);
    chk("overrun_valid", {31'h0, dv_m}, 32'h1);
    read_both();
    repeat (8) @(posedge clk);
    #1;

    // Same again, with read landing in the completion cycle of the second.
    o0 = ovr_cnt;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    fork
      begin
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
      end
      begin
        repeat (10 * DF + 9 * DF + DF / 2 + 2) @(posedge clk);
        #1;
        read = 1'b1;
        @(posedge clk);
        #1;
        read = 1'b0;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("read_same_cycle_no_overrun", 32'(ovr_cnt - o0), 32'h0);
    chk("read_same_cycle_valid", {31'h0, dv_m}, 32'h1);
    chk("read_same_cycle_data", {24'h0, dout_m}, 32'h22);
    read_both();
    repeat (8) @(posedge clk);
    #1;

    // Reset during data bit 4 aborts the frame; a fresh frame then arrives.
    rx = 1'b0;
    repeat (DF + 3 * DF + DF / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    rx  = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_dataOut", {24'h0, dout_m}, 32'h0);
    chk("midreset_state", 32'(dut_m.state_q), 32'(IDLE));
    rst = 1'b0;
    repeat (20 * DF) @(posedge clk);
    #1;
    chk("midreset_no_valid", {31'h0, dv_m}, 32'h0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b0, 1'b1);
    wait_valid(50, n);
    chk("midreset_recover_timeout", {31'h0, (n < 50)}, 32'h1);
    chk("midreset_recover_data", {24'h0, dout_m}, 32'h7E);
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive block. It pairs with the team's `emitter` transmitter: 8 data bits, no parity, 1 stop bit, and the same DELAY_FRAMES bit period.
- It sits between the board RX pin and the CPU I/O port logic.
- It synchronises the asynchronous line, samples each bit at its centre, and checks the stop bit.
- It holds each received byte until the consumer reads it, and flags framing errors and overruns.

Parameters:
- DELAY_FRAMES, 234, clocks per bit (27 MHz / 115200 baud). Minimum 4.
- MSB_FIRST, 1, 1 = first data bit on the line is bit 7, matching `emitter`; 0 = LSB first (standard UART).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  serial line, asynchronous, idle high.
- dataOut  output  8  last good received byte; stable while dataValid=1.
- dataValid  output  1  a byte is held and unread.
- read  input  1  consumer acknowledge; effective only while dataValid=1.
- frameErr  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: a held unread byte was overwritten.

Behaviour:
- Clock and reset: one clock (`clk`). Reset (`rst`) is synchronous and active-high.
- Reset values: dataOut=0, dataValid=0, frameErr=0, overrun=0, state=IDLE, counters=0, both synchroniser flops=1.
- Reset mid-frame aborts the frame immediately; no output from that partial frame.
- Synchroniser: rx passes through 2 flops to give rxS. Only rxS is used downstream.
- Counter: width $clog2(DELAY_FRAMES)+1. HALF = DELAY_FRAMES/2, integer-truncated.
- IDLE:
  - rxS==0 -> START_BIT, counter=0.
- START_BIT:
  - Wait until counter+1==HALF, then test rxS.
  - rxS==0 -> RECV_BYTE, counter=0, bitCount=0.
  - rxS==1 -> glitch; return to IDLE, no flags.
- RECV_BYTE:
  - Each time counter+1==DELAY_FRAMES: sample rxS into the shift register, reset counter.
  - MSB_FIRST=1: shift left, inserting at bit 0. MSB_FIRST=0: shift right, inserting at bit 7.
  - After the 8th sample -> STOP_BIT, counter=0.
- STOP_BIT, at counter+1==DELAY_FRAMES:
  - rxS==1 -> byte complete: dataOut<=shift, dataValid<=1; go to IDLE.
  - rxS==0 -> frameErr pulses 1 cycle, byte discarded, dataOut/dataValid unchanged; go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay until rxS==1, then go to IDLE. A break condition (line held low) therefore produces exactly one frameErr.
- Output handshake:
  - read && dataValid -> dataValid=0 next cycle.
  - read while dataValid=0 is ignored.
- Simultaneous events:
  - Byte complete while dataValid=1 and no read: dataOut is overwritten, dataValid stays 1, overrun pulses 1 cycle.
  - Byte complete in the same cycle as read: new byte loaded, dataValid stays 1, no overrun.
- Latency: dataValid rises between 9*DELAY_FRAMES+HALF and 9*DELAY_FRAMES+HALF+4 clocks after the rx falling edge at the pin.
- Back-to-back frames: a new start bit is accepted on the first IDLE cycle, so no idle gap between frames is required.
- All outputs are registered.

Decomposition:
- Shared package (uart_pkg):
  - state encodings IDLE=0, START_BIT=1, RECV_BYTE=2, STOP_BIT=3, WAIT_HIGH=4;
  - default DELAY_FRAMES (234), so `emitter` and uart_receiver share one baud constant.
- Sub-module `sync2`: 2-flop synchroniser with parameter RESET_VAL=1, reusable for other async inputs. Everything else lives in one module.

Test Plan (DELAY_FRAMES=16, MSB_FIRST=1 unless stated):
- Send 0xA5 with correct framing, read held low -> dataOut=0xA5, dataValid=1 within clock 152..156 after the start edge; assert read for 1 cycle -> dataValid=0 next cycle.
- MSB_FIRST=0, send 0x3C LSB-first -> dataOut=0x3C. Also loop back `emitter` output into rx -> received byte equals the byte written to `emitter`.
- 3-clock low glitch on idle rx -> no dataValid, no frameErr; state back in IDLE by clock 12.
- Send 0x55 with stop bit low, then hold rx low 40 bits, then release and send 0x12 -> exactly one frameErr pulse; 0x55 not presented; dataOut=0x12 valid afterwards.
- Send 0x11 then 0x22 back-to-back without read -> overrun pulses once, dataOut=0x22. Repeat with read asserted in the 0x22 completion cycle -> no overrun, dataValid=1, dataOut=0x22.
- Assert rst mid-frame at data bit 4, then send 0x7E -> no output from the aborted frame; dataOut=0x7E valid.
